// File: rtl/axi_fifo_if.sv
// axi_fifo_if: upstream beat inputs, downstream head outputs and fill level of axi_fifo.
// slave is the FIFO side; master is whatever feeds and drains it.
interface axi_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      DATA_in;
  logic            TVALID_in;
  logic            TLAST_in;
  logic            TREADY_in;
  logic [7:0]      DATA_out;
  logic            TVALID_out;
  logic            TLAST_out;
  logic            TREADY_out;
  logic [ADDR_W:0] FILL_LEVEL;

  modport slave (
    input  DATA_in, TVALID_in, TLAST_in, TREADY_out,
    output TREADY_in, DATA_out, TVALID_out, TLAST_out, FILL_LEVEL
  );

  modport master (
    output DATA_in, TVALID_in, TLAST_in, TREADY_out,
    input  TREADY_in, DATA_out, TVALID_out, TLAST_out, FILL_LEVEL
  );
endinterface

// File: rtl/axi_fifo.sv
// axi_fifo: first-word-fall-through stream FIFO of {TLAST, 8-bit data} beats.
// Define AXI_FIFO_PACKET_MODE_EN to hold the output until a whole packet is stored.
module axi_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic      ACLK,
  input  logic      ARESETn,
  axi_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   fill;
  logic [8:0]        head;
  logic              wr_en;
  logic              rd_en;
  logic              not_empty;
  logic              head_valid;

  assign not_empty = (fill != '0);
  assign head      = mem[rd_ptr];

  // Full blocks writes outright, even when a read frees a slot this cycle.
  assign bus.TREADY_in  = ARESETn && (fill != FULL_LEVEL);
  assign bus.TVALID_out = ARESETn && head_valid;
  assign bus.DATA_out   = bus.TVALID_out ? head[7:0] : 8'h00;
  assign bus.TLAST_out  = bus.TVALID_out && head[8];
  assign bus.FILL_LEVEL = fill;

  assign wr_en = bus.TVALID_in && bus.TREADY_in;
  assign rd_en = bus.TVALID_out && bus.TREADY_out;

  // NOTE: storage is deliberately not reset; clearing the pointers is enough to
  // discard its contents, and a resettable array would cost a mux per bit.
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= {bus.TLAST_in, bus.DATA_in};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

`ifdef AXI_FIFO_PACKET_MODE_EN
  logic [ADDR_W:0] pkt_cnt;
  logic            flush_q;
  logic            flush_start;
  logic            wr_last;
  logic            rd_last;

  assign wr_last = wr_en && bus.TLAST_in;
  assign rd_last = rd_en && head[8];

  // A full FIFO holding no packet end can never complete one: drain it instead.
  assign flush_start = (fill == FULL_LEVEL) && (pkt_cnt == '0);
  assign head_valid  = not_empty && ((pkt_cnt != '0) || flush_q || flush_start);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      pkt_cnt <= '0;
      flush_q <= 1'b0;
    end else begin
      case ({wr_last, rd_last})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
      if (rd_last) begin
        flush_q <= 1'b0;
      end else if (flush_start) begin
        flush_q <= 1'b1;
      end
    end
  end
`else
  assign head_valid = not_empty;
`endif

endmodule
